// File: rtl/deadlock_watchdog_monitor.sv
// Kernel deadlock watchdog: flags a stall that persists for a programmable number of cycles, then snapshots and counts it.
// Latency: block and block_pulse rise the cycle after the eff_thr-th consecutive stall cycle; all outputs are registered.
// Backpressure: none, pure observer. Defining DEADLOCK_MON_MAXSTALL_EN adds the max_stall output.
module deadlock_watchdog_monitor #(
  parameter int NUM_INST  = 5,
  parameter int NUM_AXIS  = 2,
  parameter int TIMEOUT_W = 16,
  parameter int EVT_W     = 8,
  parameter int STICKY    = 1
) (
  input  logic                 kernel_monitor_clock,
  input  logic                 kernel_monitor_reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] threshold,
  input  logic [NUM_AXIS-1:0]  axis_block_sigs,
  input  logic [NUM_INST-1:0]  inst_idle_sigs,
  input  logic [NUM_INST-1:0]  inst_block_sigs,
  output logic                 block,
  output logic                 block_pulse,
  output logic [TIMEOUT_W-1:0] stall_cnt,
  output logic [NUM_INST-1:0]  inst_snapshot,
  output logic [NUM_AXIS-1:0]  axis_snapshot,
  output logic [EVT_W-1:0]     event_cnt
`ifdef DEADLOCK_MON_MAXSTALL_EN
  ,
  output logic [TIMEOUT_W-1:0] max_stall
`endif
);

  typedef enum logic [0:0] {WATCH = 1'b0, HIT = 1'b1} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 cand;
  logic                 detect;
  logic                 enter_hit;
  logic [TIMEOUT_W-1:0] eff_thr;
  logic [TIMEOUT_W:0]   cnt_inc;

  // An all-idle kernel with nothing blocked has simply finished; it is not a stall.
  assign cand = enable & (&(inst_idle_sigs | inst_block_sigs))
              & ((|inst_block_sigs) | (|axis_block_sigs));

  assign eff_thr   = (threshold == '0) ? {{(TIMEOUT_W-1){1'b0}}, 1'b1} : threshold;
  assign cnt_inc   = {1'b0, stall_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign detect    = cand & (cnt_inc >= {1'b0, eff_thr});
  assign enter_hit = (state == WATCH) & detect & ~clear;

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      state <= WATCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WATCH: begin
        if (detect && !clear) begin
          state_nxt = HIT;
        end
      end
      HIT: begin
        if (clear || ((STICKY == 0) && !cand)) begin
          state_nxt = WATCH;
        end
      end
      default: state_nxt = WATCH;
    endcase
  end

  always_comb begin
    block = (state == HIT);
  end

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      stall_cnt <= '0;
    end else if (clear || !cand) begin
      stall_cnt <= '0;
    end else if (stall_cnt != {TIMEOUT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Snapshots and the event counter only move on the WATCH->HIT edge; clear leaves them alone.
  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      block_pulse   <= 1'b0;
      inst_snapshot <= '0;
      axis_snapshot <= '0;
      event_cnt     <= '0;
    end else begin
      block_pulse <= enter_hit;
      if (enter_hit) begin
        inst_snapshot <= inst_block_sigs;
        axis_snapshot <= axis_block_sigs;
        if (event_cnt != {EVT_W{1'b1}}) begin
          event_cnt <= event_cnt + 1'b1;
        end
      end
    end
  end

`ifdef DEADLOCK_MON_MAXSTALL_EN
  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset || clear) begin
      max_stall <= '0;
    end else if (stall_cnt > max_stall) begin
      max_stall <= stall_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_deadlock_watchdog_monitor.sv
// Directed bench for deadlock_watchdog_monitor: a non-sticky and a sticky instance share stimulus
// and are compared every cycle against a run-length model, plus hand-computed literal checks.
module tb_deadlock_watchdog_monitor;

  localparam int TW = 6;
  localparam int EW = 8;
  localparam int CNT_MAX = (1 << TW) - 1;
  localparam int EVT_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, clr;
  logic [TW-1:0] thr;
  logic [1:0]    axis;
  logic [4:0]    idle, blk;

  logic [1:0]    block_o, pulse_o;
  logic [TW-1:0] cnt_o   [2];
  logic [4:0]    isnap_o [2];
  logic [1:0]    asnap_o [2];
  logic [EW-1:0] evt_o   [2];
`ifdef DEADLOCK_MON_MAXSTALL_EN
  logic [TW-1:0] max_o   [2];
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Index 0 is STICKY=0, index 1 is STICKY=1.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    deadlock_watchdog_monitor #(
      .NUM_INST(5), .NUM_AXIS(2), .TIMEOUT_W(TW), .EVT_W(EW), .STICKY(g)
    ) u_dut (
      .kernel_monitor_clock(clk),
      .kernel_monitor_reset(rst),
      .enable(en),
      .clear(clr),
      .threshold(thr),
      .axis_block_sigs(axis),
      .inst_idle_sigs(idle),
      .inst_block_sigs(blk),
      .block(block_o[g]),
      .block_pulse(pulse_o[g]),
      .stall_cnt(cnt_o[g]),
      .inst_snapshot(isnap_o[g]),
      .axis_snapshot(asnap_o[g]),
      .event_cnt(evt_o[g])
`ifdef DEADLOCK_MON_MAXSTALL_EN
      ,
      .max_stall(max_o[g])
`endif
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: run length of the stall condition plus a per-instance "blocked" flag.
  int   m_run, m_max;
  bit   m_blk   [2];
  bit   m_pulse [2];
  int   m_evt   [2];
  int   m_isnap [2];
  int   m_asnap [2];

  always @(posedge clk) begin
    bit c, fire;
    int t;
    if (rst) begin
      m_run = 0; m_max = 0;
      for (int s = 0; s < 2; s++) begin
        m_blk[s] = 0; m_pulse[s] = 0; m_evt[s] = 0; m_isnap[s] = 0; m_asnap[s] = 0;
      end
    end else begin
      c = en && ((idle | blk) == 5'b11111) && (blk != 0 || axis != 0);
      t = (thr == 0) ? 1 : int'(thr);
      for (int s = 0; s < 2; s++) begin
        fire = 0;
        if (!m_blk[s]) begin
          fire = c && (m_run + 1 >= t) && !clr;
          if (fire) begin
            m_blk[s]   = 1;
            m_isnap[s] = int'(blk);
            m_asnap[s] = int'(axis);
            if (m_evt[s] < EVT_MAX) m_evt[s]++;
          end
        end else if (clr || (s == 0 && !c)) begin
          m_blk[s] = 0;
        end
        m_pulse[s] = fire;
      end
      if (clr) m_max = 0;
      else if (m_run > m_max) m_max = m_run;
      if (!c || clr) m_run = 0;
      else if (m_run < CNT_MAX) m_run++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        chk(s ? "block_sticky" : "block_nonsticky", int'(block_o[s]), int'(m_blk[s]));
        chk(s ? "pulse_sticky" : "pulse_nonsticky", int'(pulse_o[s]), int'(m_pulse[s]));
        chk(s ? "stall_cnt_sticky" : "stall_cnt_nonsticky", int'(cnt_o[s]), m_run);
        chk(s ? "inst_snap_sticky" : "inst_snap_nonsticky", int'(isnap_o[s]), m_isnap[s]);
        chk(s ? "axis_snap_sticky" : "axis_snap_nonsticky", int'(asnap_o[s]), m_asnap[s]);
        chk(s ? "event_cnt_sticky" : "event_cnt_nonsticky", int'(evt_o[s]), m_evt[s]);
`ifdef DEADLOCK_MON_MAXSTALL_EN
        chk(s ? "max_stall_sticky" : "max_stall_nonsticky", int'(max_o[s]), m_max);
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic stall(input logic [4:0] b, input logic [4:0] i, input logic [1:0] a);
    blk = b; idle = i; axis = a;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; thr = '0; axis = '0; idle = '0; blk = '0;
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("reset_block", int'(block_o[1]), 0);
    chk("reset_event_cnt", int'(evt_o[1]), 0);
    rst = 1'b0;
    en  = 1'b1;

    // Threshold 4, instance 0 blocked, rest idle: block appears 4 cycles later.
    thr = 4;
    stall(5'b00001, 5'b11110, 2'b00);
    step(3);
    chk("t1_stall_cnt_c3", int'(cnt_o[0]), 3);
    chk("t1_block_c3", int'(block_o[0]), 0);
    step(1);
    chk("t1_block_c4", int'(block_o[0]), 1);
    chk("t1_pulse_c4", int'(pulse_o[1]), 1);
    step(1);
    chk("t1_pulse_c5", int'(pulse_o[1]), 0);
    chk("t1_inst_snap", int'(isnap_o[1]), 1);
    chk("t1_event_cnt", int'(evt_o[1]), 1);
    step(5);
    stall(5'b00000, 5'b00000, 2'b00);
    step(1);
    chk("t1_release_nonsticky", int'(block_o[0]), 0);
    chk("t1_release_sticky", int'(block_o[1]), 1);
    step(2);
    clr = 1'b1; step(1); clr = 1'b0; step(1);

    // Gap cycle breaks the run: never reaches threshold 4.
    stall(5'b00001, 5'b11110, 2'b00);
    step(3);
    idle = 5'b11100;
    step(1);
    chk("t2_gap_stall_cnt", int'(cnt_o[0]), 0);
    idle = 5'b11110;
    step(3);
    chk("t2_no_block", int'(block_o[1]), 0);
    stall(5'b00000, 5'b00000, 2'b00);
    step(1);

    // Threshold 2, two separate stalls after a fresh reset.
    rst = 1'b1; step(1); rst = 1'b0;
    thr = 2;
    stall(5'b00010, 5'b11101, 2'b00);
    step(6);
    stall(5'b00000, 5'b00000, 2'b00);
    step(2);
    stall(5'b00010, 5'b11101, 2'b00);
    step(6);
    chk("t3_event_cnt_nonsticky", int'(evt_o[0]), 2);
    chk("t3_event_cnt_sticky", int'(evt_o[1]), 1);
    stall(5'b00000, 5'b00000, 2'b00);
    step(2);
    chk("t4_sticky_held", int'(block_o[1]), 1);

    // Clear coinciding with a fresh detect: clear wins for both instances.
    thr = 1;
    clr = 1'b1;
    stall(5'b00100, 5'b11011, 2'b00);
    step(1);
    chk("t4_clear_block", int'(block_o[1]), 0);
    chk("t4_clear_pulse", int'(pulse_o[0]), 0);
    chk("t4_clear_stall_cnt", int'(cnt_o[1]), 0);
    clr = 1'b0;
    step(2);
    clr = 1'b1;
    stall(5'b00000, 5'b00000, 2'b00);
    step(1);
    clr = 1'b0;

    // Threshold 0 acts as 1; AXIS-only block with every instance idle.
    thr = 0;
    stall(5'b00000, 5'b11111, 2'b01);
    step(1);
    chk("t5_block", int'(block_o[1]), 1);
    chk("t5_axis_snap", int'(asnap_o[1]), 1);
    clr = 1'b1;
    stall(5'b00000, 5'b00000, 2'b00);
    step(1);
    clr = 1'b0;
    stall(5'b00000, 5'b11111, 2'b00);
    step(5);
    chk("t5_all_idle_block", int'(block_o[0]), 0);
    chk("t5_all_idle_cnt", int'(cnt_o[0]), 0);

    // Enable low suppresses an otherwise valid stall.
    en = 1'b0;
    stall(5'b00001, 5'b11110, 2'b00);
    step(3);
    chk("t5_enable_low", int'(block_o[0]), 0);
    en = 1'b1;

    // Drive many detections through the non-sticky instance to saturate event_cnt.
    rst = 1'b1; step(1); rst = 1'b0;
    thr = 1;
    for (int k = 0; k < 260; k++) begin
      stall(5'b00001, 5'b11110, 2'b00);
      step(1);
      stall(5'b00000, 5'b00000, 2'b00);
      step(1);
    end
    chk("t6_event_sat", int'(evt_o[0]), 255);

    // Long stall saturates stall_cnt, then reset in HIT zeroes everything.
    stall(5'b10000, 5'b01111, 2'b10);
    step(70);
    chk("t6_stall_cnt_sat", int'(cnt_o[0]), CNT_MAX);
    rst = 1'b1;
    step(1);
    chk("t6_rst_block", int'(block_o[1]), 0);
    chk("t6_rst_pulse", int'(pulse_o[1]), 0);
    chk("t6_rst_stall_cnt", int'(cnt_o[1]), 0);
    chk("t6_rst_inst_snap", int'(isnap_o[1]), 0);
    chk("t6_rst_axis_snap", int'(asnap_o[1]), 0);
    chk("t6_rst_event_cnt", int'(evt_o[0]), 0);
    rst = 1'b0;
    stall(5'b00000, 5'b00000, 2'b00);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deadlock_watchdog_monitor.md
Name: deadlock_watchdog_monitor

Overview:
Parametrised successor to the per-kernel deadlock monitor. Takes per-instance idle/block status and per-channel AXIS block status from any number of dataflow processes. Flags a kernel deadlock only after the stall condition has persisted for a runtime-programmable number of cycles. Captures diagnostic snapshots and counts events; instantiated once per kernel in the simulation monitor top and usable as on-chip debug logic.

Parameters:
NUM_INST, 5, number of monitored dataflow instances (>=1)
NUM_AXIS, 2, number of monitored AXIS ports (>=1)
TIMEOUT_W, 16, width of threshold and stall counter
EVT_W, 8, width of saturating event counter
STICKY, 1, 1 = block held until clear; 0 = block follows stall condition

Ports:
kernel_monitor_clock  in  1  single clock, all logic rising-edge
kernel_monitor_reset  in  1  synchronous, active-high reset
enable  in  1  monitoring enable; low forces stall condition false
clear  in  1  synchronous clear of block flag and stall counter
threshold  in  TIMEOUT_W  consecutive stall cycles required; 0 treated as 1
axis_block_sigs  in  NUM_AXIS  1 = AXIS port blocked
inst_idle_sigs  in  NUM_INST  1 = instance idle
inst_block_sigs  in  NUM_INST  1 = instance blocked on FIFO/continue
block  out  1  deadlock detected (registered)
block_pulse  out  1  one-cycle pulse on block rising edge
stall_cnt  out  TIMEOUT_W  current consecutive stall cycles, saturating
inst_snapshot  out  NUM_INST  inst_block_sigs captured at detection
axis_snapshot  out  NUM_AXIS  axis_block_sigs captured at detection
event_cnt  out  EVT_W  number of detections, saturating at all-ones

Behaviour:
- Combinational stall condition: cand = enable & (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs | |axis_block_sigs).
- All-idle with no block is not a stall.
- eff_thr = (threshold == 0) ? 1 : threshold.
- stall_cnt register:
  - 0 when !cand or clear.
  - Otherwise increments by 1 each cycle, saturating at 2^TIMEOUT_W-1 (no wrap).
- Detect = cand & (stall_cnt + 1 >= eff_thr), compared at TIMEOUT_W+1 bits.
  - block asserts the cycle after the eff_thr-th consecutive cand cycle. Example: threshold 4, cand high from cycle 0 gives block=1 at cycle 4.
- State machine, 2 states:
  - WATCH (block=0). On detect & !clear: go to HIT, pulse block_pulse, latch snapshots, increment event_cnt.
  - HIT (block=1), STICKY=1: leave only on clear.
  - HIT (block=1), STICKY=0: return to WATCH on !cand or clear.
  - Re-entry into HIT requires stall_cnt to reach eff_thr again from 0.
- Snapshots are updated only on the WATCH->HIT transition and hold otherwise. clear does not affect snapshots.
- event_cnt is cleared only by reset; it saturates.
- clear and detect in the same cycle: clear wins. No transition, no pulse, stall_cnt=0.
- threshold change mid-stall takes effect immediately against the current stall_cnt.
- Reset (synchronous, any state): block=0, block_pulse=0, stall_cnt=0, snapshots=0, event_cnt=0, state=WATCH. Reset has priority over all inputs.
- No combinational path from inputs to outputs.

Optional Feature:
DEADLOCK_MON_MAXSTALL_EN
- Defined: adds output max_stall [TIMEOUT_W].
  - Holds the largest stall_cnt reached since reset or clear. Updated the cycle after stall_cnt exceeds it.
  - Reset and clear set it to 0.
- Undefined: port and register absent. All other behaviour is identical.

Test Plan:
- Threshold 4, enable=1, inst_block=00001, others idle, held 10 cycles -> block=1 at cycle 4; block_pulse 1 cycle; inst_snapshot=00001; event_cnt=1.
- Same stall for 3 cycles, one gap cycle (inst_idle bit cleared), then 3 more cycles -> block stays 0; stall_cnt returns to 0 at the gap.
- STICKY=0: stall 6 cycles with threshold 2, then stall released -> block drops the cycle after release; second stall -> event_cnt=2.
- STICKY=1: after detection, release stall -> block stays 1; pulse clear together with a fresh detect -> block=0, no pulse, stall_cnt=0.
- Threshold 0, all instances idle, axis_block=01 -> block=1 after 1 cycle; axis_snapshot=01. All idle, axis_block=00 -> never blocks.
- Force 256 detections with EVT_W=8 -> event_cnt saturates at 255. Assert reset mid-HIT -> all outputs 0 next cycle.
